// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Unsigned restoring divider, one quotient bit per clock, MSB first.
//            Optional macro SEQ_DIVIDER_DZ_EN adds a dz flag and a b=0 bypass.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
`ifdef SEQ_DIVIDER_DZ_EN
  output logic             dz,
`endif
  output logic             done
);

  localparam int                  c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_dvd;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  // The stored remainder is always below the divisor, so WIDTH bits suffice;
  // the WIDTH+1-bit partial remainder only exists after the shift.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_DIVIDER_DZ_EN
      dz      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          r_dvd <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            q       <= w_quo_nxt;
            r       <= w_rem_nxt;
`ifdef SEQ_DIVIDER_DZ_EN
            dz      <= 1'b0;
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a new request
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            r_dvd <= a;
            r_dvs <= b;
            r_rem <= '0;
            r_cnt <= '0;
`ifdef SEQ_DIVIDER_DZ_EN
            if (b == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              q       <= '1;
              r       <= a;
              dz      <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
`else
            r_state <= S_RUN;
            busy    <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Self-checking bench for seq_divider (WIDTH=8), cycle model + vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
`ifdef SEQ_DIVIDER_DZ_EN
  logic         dz;
  logic         m_dz = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model: cycles left in the iteration and the expected results
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
`ifdef SEQ_DIVIDER_DZ_EN
    .dz    (dz),
`endif
    .done  (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0;
`ifdef SEQ_DIVIDER_DZ_EN
      m_dz = 1'b0;
`endif
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        if (m_b == 0) begin m_q = '1; m_r = m_a; end
        else begin m_q = m_a / m_b; m_r = m_a % m_b; end
`ifdef SEQ_DIVIDER_DZ_EN
        m_dz = 1'b0;
`endif
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_a = a; m_b = b;
`ifdef SEQ_DIVIDER_DZ_EN
        if (b == 0) begin m_done = 1'b1; m_q = '1; m_r = a; m_dz = 1'b1; end
        else m_left = W;
`else
        m_left = W;
`endif
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("q", q, m_q);
      check("r", r, m_r);
`ifdef SEQ_DIVIDER_DZ_EN
      check("dz", dz, m_dz);
`endif
    end
  endtask

  // Called on a falling edge; returns on the falling edge where done is seen.
  // lat counts rising edges from the accepting edge to the one raising done.
  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       output int lat, output int nb);
    start = 1'b1; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, nb, ndone;
    logic [W-1:0] ra, rb;
    fork monitor(); join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_op(8'd200, 8'd7, lat, nb);
    check("basic_lat", lat, 9);
    check("basic_busy_cycles", nb, 8);
    check("basic_q", q, 28);
    check("basic_r", r, 4);

    @(negedge clk); do_op(8'd255, 8'd1, lat, nb);
    check("c255_1_q", q, 255); check("c255_1_r", r, 0);
    @(negedge clk); do_op(8'd5, 8'd9, lat, nb);
    check("c5_9_q", q, 0); check("c5_9_r", r, 5);
    @(negedge clk); do_op(8'd255, 8'd255, lat, nb);
    check("c255_255_q", q, 1); check("c255_255_r", r, 0);

    @(negedge clk); do_op(8'd42, 8'd0, lat, nb);
    check("dz_q", q, 255); check("dz_r", r, 42);
`ifdef SEQ_DIVIDER_DZ_EN
    check("dz_lat", lat, 1);
    check("dz_flag", dz, 1);
    @(negedge clk); do_op(8'd9, 8'd3, lat, nb);
    check("dz_clear", dz, 0);
    check("dz_clear_q", q, 3);
`else
    check("dz_lat", lat, 9);
`endif

    // Start during RUN is ignored, start during DONE is taken back-to-back
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd3;
    @(negedge clk); start = 1'b0; lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b1; a = 8'd50; b = 8'd5;
    @(negedge clk); start = 1'b0; lat++;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_first_lat", lat, 9);
    check("b2b_first_q", q, 33);
    check("b2b_first_r", r, 1);
    do_op(8'd50, 8'd5, lat, nb);
    check("b2b_second_lat", lat, 9);
    check("b2b_second_q", q, 10);
    check("b2b_second_r", r, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q, 0);
    check("arst_r", r, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    ndone = 0;
    repeat (2) begin @(negedge clk); if (done) ndone++; end
    check("arst_no_done", ndone, 0);
    rst_n = 1'b1;
    do_op(8'd9, 8'd2, lat, nb);
    check("post_rst_lat", lat, 9);
    check("post_rst_q", q, 4);
    check("post_rst_r", r, 1);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(1, 255));
      do_op(ra, rb, lat, nb);
      check("rand_identity", int'(q) * int'(rb) + int'(r), int'(ra));
      check("rand_r_lt_b", r < rb, 1);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
